mod_sub_arbiter: RTL and testbench

- Shares one combinational mod_sub unit (c = (a - b) mod q, 24-bit operands, 23-bit modulus/result) among N_REQ requesters.
- Requesters are polynomial/NTT coefficient engines.
- Round-robin arbitration, 2-stage valid/ready pipeline, tagged responses.
- Sits between requester engines and the single mod_sub instance, which sits outside this block.

---
 rtl/mod_sub_arbiter.sv | 137 +++++++++++++
 tb/tb_mod_sub_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_sub_arbiter.sv
// Round-robin arbiter sharing one combinational mod_sub unit.
// Two-stage valid/ready pipeline: operand register, then response register.
module mod_sub_arbiter #(
    parameter int N_REQ = 4,
    parameter int A_W   = 24,
    parameter int Q_W   = 23,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic [N_REQ*A_W-1:0] req_a_i,
    input  logic [N_REQ*A_W-1:0] req_b_i,
    input  logic [Q_W-1:0]       q_i,
    output logic [A_W-1:0]       sub_a_o,
    output logic [A_W-1:0]       sub_b_o,
    output logic [Q_W-1:0]       sub_q_o,
    input  logic [Q_W-1:0]       sub_c_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic [Q_W-1:0]       rsp_c_o,
    output logic                 idle_o
);

    localparam logic [ID_W-1:0] LAST = ID_W'(N_REQ - 1);

    logic                 s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]      s1_id_q, s1_id_d;
    logic [A_W-1:0]       sub_a_q, sub_a_d;
    logic [A_W-1:0]       sub_b_q, sub_b_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [Q_W-1:0]       rsp_c_q, rsp_c_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;

    logic                 adv1, adv2;
    logic                 found_hi, found_lo;
    logic [ID_W-1:0]      idx_hi, idx_lo, gnt_idx;
    logic                 hs;
    logic [A_W-1:0]       a_sel, b_sel;

    // Round-robin search: first valid at or above ptr, else lowest valid.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_hi && req_valid_i[i] && (ID_W'(i) >= ptr_q)) begin
                found_hi = 1'b1;
                idx_hi   = ID_W'(i);
            end
            if (!found_lo && req_valid_i[i]) begin
                found_lo = 1'b1;
                idx_lo   = ID_W'(i);
            end
        end
        gnt_idx = found_hi ? idx_hi : idx_lo;
    end

    // Advance conditions, grant qualification and operand selection.
    always_comb begin
        adv2        = !rsp_valid_q || rsp_ready_i;
        adv1        = !s1_valid_q || adv2;
        hs          = found_lo && adv1;
        req_ready_o = '0;
        a_sel       = '0;
        b_sel       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_idx == ID_W'(k)) begin
                req_ready_o[k] = hs;
                a_sel          = req_a_i[k*A_W +: A_W];
                b_sel          = req_b_i[k*A_W +: A_W];
            end
        end
    end

    // Next-state for both pipeline stages and the round-robin pointer.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_id_d     = s1_id_q;
        sub_a_d     = sub_a_q;
        sub_b_d     = sub_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_c_d     = rsp_c_q;
        ptr_d       = ptr_q;
        if (adv2) begin
            rsp_valid_d = s1_valid_q;
            rsp_id_d    = s1_id_q;
            rsp_c_d     = sub_c_i;
        end
        if (adv1) begin
            s1_valid_d = hs;
        end
        if (hs) begin
            s1_id_d = gnt_idx;
            sub_a_d = a_sel;
            sub_b_d = b_sel;
            ptr_d   = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Pipeline and pointer registers; reset drops in-flight work.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            sub_a_q     <= '0;
            sub_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_c_q     <= '0;
            ptr_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            sub_a_q     <= sub_a_d;
            sub_b_q     <= sub_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_c_q     <= rsp_c_d;
            ptr_q       <= ptr_d;
        end
    end

    assign sub_a_o     = sub_a_q;
    assign sub_b_o     = sub_b_q;
    assign sub_q_o     = q_i;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_c_o     = rsp_c_q;
    assign idle_o      = !s1_valid_q && !rsp_valid_q;

endmodule

// File: tb/tb_mod_sub_arbiter.sv
// Directed-vector bench for mod_sub_arbiter.
// A behavioural mod_sub closes the loop on sub_a_o/sub_b_o/sub_q_o.
module tb_mod_sub_arbiter;

    localparam int N = 4;
    localparam int AW = 24;
    localparam int QW = 23;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*AW-1:0] req_b;
    logic [QW-1:0]   q;
    logic [AW-1:0]   sub_a;
    logic [AW-1:0]   sub_b;
    logic [QW-1:0]   sub_q;
    logic [QW-1:0]   sub_c;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [QW-1:0]   rsp_c;
    logic            idle;

    int vectors = 0;
    int miscompares = 0;
    longint d_m;

    always #5 clk = ~clk;

    // Behavioural mod_sub: c = (a - b) mod q
    always_comb begin
        d_m = longint'(sub_a) - longint'(sub_b);
        d_m = d_m % longint'(sub_q);
        if (d_m < 0) d_m = d_m + longint'(sub_q);
        sub_c = d_m[QW-1:0];
    end

    mod_sub_arbiter #(.N_REQ(N), .A_W(AW), .Q_W(QW), .ID_W(IW)) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_a_i(req_a),
        .req_b_i(req_b),
        .q_i(q),
        .sub_a_o(sub_a),
        .sub_b_o(sub_b),
        .sub_q_o(sub_q),
        .sub_c_i(sub_c),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id),
        .rsp_c_o(rsp_c),
        .idle_o(idle)
    );

    task test_reset();
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL rst_idle got %b want 1", idle); end
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_ready got %b want 0000", req_ready); end
        vectors++; if (rsp_c !== 23'd0) begin miscompares++; $display("FAIL rst_rsp_c got %0d want 0", rsp_c); end
        vectors++; if (rsp_id !== 2'd0) begin miscompares++; $display("FAIL rst_rsp_id got %0d want 0", rsp_id); end
        vectors++; if (sub_a !== 24'd0 || sub_b !== 24'd0) begin miscompares++; $display("FAIL rst_sub_ab got %0d/%0d want 0/0", sub_a, sub_b); end
        vectors++; if (sub_q !== 23'd40) begin miscompares++; $display("FAIL rst_sub_q got %0d want 40", sub_q); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task test_single();
        req_a[0*AW +: AW] = 24'd20;
        req_b[0*AW +: AW] = 24'd13;
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL single_ready got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        vectors++; if (sub_a !== 24'd20 || sub_b !== 24'd13) begin miscompares++; $display("FAIL single_s1_ops got %0d/%0d want 20/13", sub_a, sub_b); end
        vectors++; if (rsp_valid !== 1'b0 || idle !== 1'b0) begin miscompares++; $display("FAIL single_s1 got v=%b idle=%b want v=0 idle=0", rsp_valid, idle); end
        @(negedge clk);
        #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_c !== 23'd7) begin miscompares++; $display("FAIL single_rsp got v=%b id=%0d c=%0d want v=1 id=0 c=7", rsp_valid, rsp_id, rsp_c); end
        @(negedge clk);
        #1;
        vectors++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin miscompares++; $display("FAIL single_after got v=%b idle=%b want v=0 idle=1", rsp_valid, idle); end
    endtask

    task test_wrap();
        @(negedge clk);
        req_a[1*AW +: AW] = 24'd7;
        req_b[1*AW +: AW] = 24'd13;
        req_valid = 4'b0010;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL wrap_ready got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_c !== 23'd34) begin miscompares++; $display("FAIL wrap_rsp got v=%b id=%0d c=%0d want v=1 id=1 c=34", rsp_valid, rsp_id, rsp_c); end
        @(negedge clk);
        #1;
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL wrap_idle got %b want 1", idle); end
    endtask

    // Pointer is 2 here (last grant went to req1).
    task test_priority();
        @(negedge clk);
        req_a[2*AW +: AW] = 24'd5;
        req_b[2*AW +: AW] = 24'd1;
        req_valid = 4'b0100;
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL prio_ready2 got %b want 0100", req_ready); end
        @(negedge clk);
        req_a[1*AW +: AW] = 24'd3;
        req_b[1*AW +: AW] = 24'd1;
        req_a[3*AW +: AW] = 24'd9;
        req_b[3*AW +: AW] = 24'd2;
        req_valid = 4'b1010;
        #1;
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL prio_ready3 got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL prio_ready1 got %b want 0010", req_ready); end
        vectors++; if (sub_a !== 24'd9) begin miscompares++; $display("FAIL prio_s1_a got %0d want 9", sub_a); end
        vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_c !== 23'd4) begin miscompares++; $display("FAIL prio_rsp2 got v=%b id=%0d c=%0d want v=1 id=2 c=4", rsp_valid, rsp_id, rsp_c); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_c !== 23'd7) begin miscompares++; $display("FAIL prio_rsp3 got v=%b id=%0d c=%0d want v=1 id=3 c=7", rsp_valid, rsp_id, rsp_c); end
        @(negedge clk);
        #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_c !== 23'd2) begin miscompares++; $display("FAIL prio_rsp1 got v=%b id=%0d c=%0d want v=1 id=1 c=2", rsp_valid, rsp_id, rsp_c); end
        @(negedge clk);
        #1;
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL prio_idle got %b want 1", idle); end
    endtask

    // Pointer is 2 here: grants run 2,3,0,1,2,3,0,1.
    task test_fairness();
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            req_a[k*AW +: AW] = AW'(k + 20);
            req_b[k*AW +: AW] = AW'(k);
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            if (t > 0) @(negedge clk);
            if (t == 8) req_valid = 4'b0000;
            #1;
            if (t < 8) begin
                exp_rdy = 4'b0001 << ((2 + t) % 4);
                vectors++; if (req_ready !== exp_rdy) begin miscompares++; $display("FAIL fair_ready t=%0d got %b want %b", t, req_ready, exp_rdy); end
            end
            if (t >= 2) begin
                vectors++; if (rsp_valid !== 1'b1 || rsp_id !== IW'(t % 4) || rsp_c !== 23'd20) begin miscompares++; $display("FAIL fair_rsp t=%0d got v=%b id=%0d c=%0d want v=1 id=%0d c=20", t, rsp_valid, rsp_id, rsp_c, t % 4); end
            end
        end
        @(negedge clk);
        #1;
        vectors++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin miscompares++; $display("FAIL fair_end got v=%b idle=%b want v=0 idle=1", rsp_valid, idle); end
    endtask

    // Pointer is 2 here: req2 then req3 accepted, then stall.
    task test_backpressure();
        int hs;
        hs = 0;
        @(negedge clk);
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        for (int t = 0; t < 6; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            hs += $countones(req_valid & req_ready);
            if (t == 0) begin
                vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL bp_ready0 got %b want 0100", req_ready); end
            end else if (t == 1) begin
                vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL bp_ready1 got %b want 1000", req_ready); end
            end else begin
                vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_full_ready t=%0d got %b want 0000", t, req_ready); end
                vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_c !== 23'd20 || sub_a !== 24'd23) begin miscompares++; $display("FAIL bp_hold t=%0d got v=%b id=%0d c=%0d a=%0d want v=1 id=2 c=20 a=23", t, rsp_valid, rsp_id, rsp_c, sub_a); end
            end
        end
        vectors++; if (hs !== 2) begin miscompares++; $display("FAIL bp_handshakes got %0d want 2", hs); end
        @(negedge clk);
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin miscompares++; $display("FAIL bp_rel0 got v=%b id=%0d want v=1 id=2", rsp_valid, rsp_id); end
        @(negedge clk);
        #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_c !== 23'd20) begin miscompares++; $display("FAIL bp_rel1 got v=%b id=%0d c=%0d want v=1 id=3 c=20", rsp_valid, rsp_id, rsp_c); end
        @(negedge clk);
        #1;
        vectors++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin miscompares++; $display("FAIL bp_end got v=%b idle=%b want v=0 idle=1", rsp_valid, idle); end
    endtask

    // Pointer is 0 here; req1 then req2 put in flight, then reset.
    task test_reset_mid();
        @(negedge clk);
        rsp_ready = 1'b0;
        req_a[1*AW +: AW] = 24'd1;
        req_b[1*AW +: AW] = 24'd2;
        req_a[2*AW +: AW] = 24'd8;
        req_b[2*AW +: AW] = 24'd1;
        req_valid = 4'b0010;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL rmid_ready1 got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL rmid_ready2 got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        vectors++; if (rsp_valid !== 1'b1 || idle !== 1'b0) begin miscompares++; $display("FAIL rmid_full got v=%b idle=%b want v=1 idle=0", rsp_valid, idle); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin miscompares++; $display("FAIL rmid_async got v=%b idle=%b want v=0 idle=1", rsp_valid, idle); end
        vectors++; if (rsp_c !== 23'd0 || rsp_id !== 2'd0 || sub_a !== 24'd0) begin miscompares++; $display("FAIL rmid_clr got c=%0d id=%0d a=%0d want 0/0/0", rsp_c, rsp_id, sub_a); end
        req_a[0*AW +: AW] = 24'd30;
        req_b[0*AW +: AW] = 24'd35;
        req_valid = 4'b0011;
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++; if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_ptr0 got rdy=%b v=%b want rdy=0001 v=0", req_ready, rsp_valid); end
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        vectors++; if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_stale got rdy=%b v=%b want rdy=0010 v=0", req_ready, rsp_valid); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_c !== 23'd35) begin miscompares++; $display("FAIL rmid_rsp0 got v=%b id=%0d c=%0d want v=1 id=0 c=35", rsp_valid, rsp_id, rsp_c); end
        @(negedge clk);
        #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_c !== 23'd39) begin miscompares++; $display("FAIL rmid_rsp1 got v=%b id=%0d c=%0d want v=1 id=1 c=39", rsp_valid, rsp_id, rsp_c); end
        @(negedge clk);
        #1;
        vectors++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin miscompares++; $display("FAIL rmid_end got v=%b idle=%b want v=0 idle=1", rsp_valid, idle); end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        q = 23'd40;
        test_reset();
        test_single();
        test_wrap();
        test_priority();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
